// File: rtl/dplca_pkg.sv
// dplca_pkg: claim encoding shared with the DPLCA aging block, TXOP tracking states and boolean constants.
package dplca_pkg;
  localparam logic ON = 1'b1;
  localparam logic OFF = 1'b0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [1:0] CLAIM_SOFT = 2'b00;
  localparam logic [1:0] CLAIM_HARD = 2'b01;
  localparam logic [1:0] CLAIM_NONE = 2'b10;
  typedef enum logic [1:0] {DISABLED, WAIT_BEACON, TXOP_OPEN, TXOP_BUSY} state_e;
endpackage

// File: rtl/dplca_txop_stats.sv
// dplca_txop_stats: wrapping per-class totals of issued TXOP reports.
module dplca_txop_stats
  import dplca_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        fire,
  input  logic [1:0]  claim,
  output logic [15:0] hard_total,
  output logic [15:0] soft_total,
  output logic [15:0] none_total
);
  always_ff @(posedge clk) begin
    if (clr) begin
      hard_total <= '0;
      soft_total <= '0;
      none_total <= '0;
    end else begin
      hard_total <= hard_total + 16'(fire && claim == CLAIM_HARD);
      soft_total <= soft_total + 16'(fire && claim == CLAIM_SOFT);
      none_total <= none_total + 16'(fire && claim == CLAIM_NONE);
    end
  end
endmodule

// File: rtl/dplca_txop_monitor.sv
// dplca_txop_monitor: classifies each PLCA TXOP as HARD/SOFT/NONE and reports it to the aging block.
// Define DPLCA_TXOP_STATS_EN to add the hard/soft/none report totals.
module dplca_txop_monitor
  import dplca_pkg::*;
#(
  parameter int unsigned MAX_ID = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dplca_en,
  input  logic [7:0]  plca_node_count,
  input  logic        beacon,
  input  logic        to_expired,
  input  logic        carrier,
  input  logic        commit_seen,
  input  logic        dplca_txop_table_upd,
  output logic        dplca_txop_end,
  output logic [1:0]  dplca_txop_claim,
  output logic [7:0]  dplca_txop_id,
  output logic [7:0]  overrun_cnt
`ifdef DPLCA_TXOP_STATS_EN
  ,
  output logic [15:0] hard_total,
  output logic [15:0] soft_total,
  output logic [15:0] none_total
`endif
);
  localparam logic [7:0] MAX_ID_L = 8'(MAX_ID);
  state_e state, state_nx;
  logic [7:0] cur_id, cur_id_nx, last_id, pend_id, fire_id;
  logic soft_flag, soft_flag_nx, close, last, pend, issue_ok, fire, store, drop;
  logic [1:0] close_claim, pend_claim, fire_claim;
  assign last_id = (plca_node_count == 8'd0) ? 8'd0 : plca_node_count - 8'd1;
  assign last = (cur_id == last_id) || (cur_id == MAX_ID_L);
  always_comb begin
    state_nx = state;
    cur_id_nx = cur_id;
    soft_flag_nx = soft_flag;
    close = FALSE;
    close_claim = CLAIM_NONE;
    case (state)
      DISABLED: state_nx = WAIT_BEACON;
      WAIT_BEACON: if (beacon) begin
        state_nx = TXOP_OPEN;
        cur_id_nx = '0;
        soft_flag_nx = FALSE;
      end
      TXOP_OPEN: begin
        soft_flag_nx = soft_flag | commit_seen;
        if (carrier) state_nx = TXOP_BUSY;
        else if (to_expired) begin
          close = TRUE;
          close_claim = soft_flag_nx ? CLAIM_SOFT : CLAIM_NONE;
        end
      end
      TXOP_BUSY: if (!carrier) begin
        close = TRUE;
        close_claim = CLAIM_HARD;
      end
    endcase
    if (close) begin
      state_nx = last ? WAIT_BEACON : TXOP_OPEN;
      cur_id_nx = last ? cur_id : cur_id + 8'd1;
      soft_flag_nx = FALSE;
    end
    // a beacon mid-cycle restarts at ID 0; any coincident close is still reported
    if (beacon && (state == TXOP_OPEN || state == TXOP_BUSY)) begin
      state_nx = TXOP_OPEN;
      cur_id_nx = '0;
      soft_flag_nx = FALSE;
    end
  end
  assign issue_ok = !dplca_txop_end && !dplca_txop_table_upd;
  assign fire = issue_ok && (pend || close);
  assign fire_claim = pend ? pend_claim : close_claim;
  assign fire_id = pend ? pend_id : cur_id;
  assign store = close && (!issue_ok || pend);
  assign drop = close && pend && !issue_ok;
  always_ff @(posedge clk) begin
    if (!reset_n || !dplca_en) begin
      state <= DISABLED;
      cur_id <= '0;
      soft_flag <= FALSE;
      dplca_txop_end <= OFF;
      dplca_txop_claim <= CLAIM_NONE;
      dplca_txop_id <= '0;
      pend <= FALSE;
      pend_claim <= CLAIM_NONE;
      pend_id <= '0;
      if (!reset_n) overrun_cnt <= '0;
    end else begin
      state <= state_nx;
      cur_id <= cur_id_nx;
      soft_flag <= soft_flag_nx;
      if (dplca_txop_end && dplca_txop_table_upd) dplca_txop_end <= OFF;
      if (fire) begin
        dplca_txop_end <= ON;
        dplca_txop_claim <= fire_claim;
        dplca_txop_id <= fire_id;
      end
      pend <= issue_ok ? (pend && close) : (pend || close);
      if (store && !drop) begin
        pend_claim <= close_claim;
        pend_id <= cur_id;
      end
      if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`ifdef DPLCA_TXOP_STATS_EN
  dplca_txop_stats u_stats (
    .clk       (clk),
    .clr       (!reset_n || !dplca_en),
    .fire      (fire),
    .claim     (fire_claim),
    .hard_total(hard_total),
    .soft_total(soft_total),
    .none_total(none_total)
  );
`endif
endmodule
